// File: rtl/spike_time_decoder.sv
// Decodes the arrival time of a fixed-width neuron output spike relative to the gamma start,
// checks the pulse width and reports empty gamma cycles.
module spike_time_decoder #(
  parameter int unsigned WRES = 3,
  parameter int unsigned TRES = 4
) (
  input  logic            clk,
  input  logic            rstb,
  input  logic            grst,
  input  logic            spike_in,
  output logic [TRES-1:0] spike_time,
  output logic            spike_valid,
  output logic            no_spike,
  output logic            pulse_err
);

  typedef enum logic [1:0] {StIdle, StPulse, StDone} state_e;

  // Width counter needs to reach 2^WRES+1 to flag an over-long pulse.
  localparam logic [WRES:0] WOne     = {{WRES{1'b0}}, 1'b1};
  localparam logic [WRES:0] WLegal   = {1'b1, {WRES{1'b0}}};
  localparam logic [WRES:0] WTooLong = WLegal + WOne;
  localparam logic [TRES-1:0] TMax   = '1;

  state_e          state_q, state_d;
  logic [TRES-1:0] t_q, t_d, t_now;
  logic [WRES:0]   width_q, width_d, width_inc;
  logic [TRES-1:0] cap_q, cap_d;
  logic [TRES-1:0] time_q, time_d;
  logic            prev_q, armed_q, armed_d;
  logic            valid_q, valid_d, nospk_q, nospk_d, err_q, err_d;
  logic            rise;

  assign rise      = spike_in & ~prev_q;
  assign t_now     = grst ? '0 : t_q;
  assign width_inc = width_q + WOne;

  always_comb begin
    if (grst)              t_d = '0;
    else if (t_q == TMax)  t_d = t_q;
    else                   t_d = t_q + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    width_d = width_q;
    cap_d   = cap_q;
    armed_d = armed_q;
    time_d  = time_q;
    valid_d = 1'b0;
    nospk_d = 1'b0;
    err_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (rise) begin
          cap_d   = t_now;
          width_d = WOne;
          state_d = StPulse;
        end
      end
      StPulse: begin
        if (spike_in) begin
          width_d = width_inc;
          if (width_inc == WTooLong) begin
            err_d   = 1'b1;
            state_d = StDone;
          end
        end else begin
          if (width_q == WLegal) begin
            time_d  = cap_q;
            valid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          state_d = StDone;
        end
      end
      StDone: begin
        if (rise) err_d = 1'b1;
      end
      default: state_d = StIdle;
    endcase

    // Gamma restart overrides the per-state decision.
    if (grst) begin
      if (state_q == StPulse) begin
        // A pulse still high here is truncated; prev stays 1 so it is not re-detected.
        if (spike_in) begin
          err_d   = 1'b1;
          width_d = '0;
        end
        state_d = StIdle;
      end else begin
        nospk_d = armed_q && (state_q == StIdle);
        armed_d = 1'b1;
        err_d   = 1'b0;
        state_d = StIdle;
        if (rise) begin
          cap_d   = '0;
          width_d = WOne;
          state_d = StPulse;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= StIdle;
      t_q     <= '0;
      width_q <= '0;
      cap_q   <= '0;
      time_q  <= '0;
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
      valid_q <= 1'b0;
      nospk_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      width_q <= width_d;
      cap_q   <= cap_d;
      time_q  <= time_d;
      prev_q  <= spike_in;
      armed_q <= armed_d;
      valid_q <= valid_d;
      nospk_q <= nospk_d;
      err_q   <= err_d;
    end
  end

  assign spike_time  = time_q;
  assign spike_valid = valid_q;
  assign no_spike    = nospk_q;
  assign pulse_err   = err_q;

endmodule

// File: tb/tb_spike_time_decoder.sv
// Directed bench for spike_time_decoder (WRES=3, TRES=4) with hand-computed expectations.
module tb_spike_time_decoder;

  logic       clk = 1'b0;
  logic       rstb, grst, spike_in;
  logic [3:0] spike_time;
  logic       spike_valid, no_spike, pulse_err;

  int checks = 0;
  int errors = 0;
  int n_valid, n_err, n_nospk;

  always #5 clk = ~clk;

  spike_time_decoder #(
    .WRES(3),
    .TRES(4)
  ) dut (
    .clk        (clk),
    .rstb       (rstb),
    .grst       (grst),
    .spike_in   (spike_in),
    .spike_time (spike_time),
    .spike_valid(spike_valid),
    .no_spike   (no_spike),
    .pulse_err  (pulse_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, let the edge happen, sample 1 ns later.
  task automatic cyc(input logic g, input logic s);
    grst     = g;
    spike_in = s;
    @(posedge clk);
    #1;
    n_valid += int'(spike_valid);
    n_err   += int'(pulse_err);
    n_nospk += int'(no_spike);
  endtask

  task automatic run(input logic g, input logic s, input int n);
    for (int i = 0; i < n; i++) cyc(g, s);
  endtask

  task automatic clr_counts();
    n_valid = 0;
    n_err   = 0;
    n_nospk = 0;
  endtask

  initial begin
    clr_counts();
    rstb     = 1'b0;
    grst     = 1'b0;
    spike_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_time",  32'(spike_time), 0);
    check_eq("rst_valid", 32'(spike_valid), 0);
    check_eq("rst_nospk", 32'(no_spike), 0);
    check_eq("rst_err",   32'(pulse_err), 0);
    rstb = 1'b1;

    // First grst after reset never flags; an empty gamma then does.
    cyc(1'b1, 1'b0);
    check_eq("nospk_first_grst", 32'(no_spike), 0);
    run(1'b0, 1'b0, 20);
    cyc(1'b1, 1'b0);
    check_eq("nospk_empty_gamma", 32'(no_spike), 1);

    // The t register clears at the grst edge, so cycle k after grst is t=k-1.
    // Rise at k=6 -> t=5; 8 highs then a low.
    run(1'b0, 1'b0, 5);
    run(1'b0, 1'b1, 8);
    check_eq("valid_before_low", 32'(spike_valid), 0);
    cyc(1'b0, 1'b0);
    check_eq("valid_legal", 32'(spike_valid), 1);
    check_eq("time_legal",  32'(spike_time), 5);
    check_eq("err_legal",   32'(pulse_err), 0);
    cyc(1'b0, 1'b0);
    check_eq("valid_one_cycle", 32'(spike_valid), 0);
    check_eq("time_held",       32'(spike_time), 5);

    // Short pulse (7) then long pulse (9).
    cyc(1'b1, 1'b0);
    check_eq("nospk_after_spike", 32'(no_spike), 0);
    run(1'b0, 1'b1, 7);
    cyc(1'b0, 1'b0);
    check_eq("err_short",   32'(pulse_err), 1);
    check_eq("valid_short", 32'(spike_valid), 0);
    cyc(1'b1, 1'b0);
    run(1'b0, 1'b1, 8);
    check_eq("err_at_8_high", 32'(pulse_err), 0);
    cyc(1'b0, 1'b1);
    check_eq("err_at_9_high", 32'(pulse_err), 1);
    clr_counts();
    run(1'b0, 1'b1, 2);
    run(1'b0, 1'b0, 2);
    check_eq("done_ignores_err",   n_err, 0);
    check_eq("done_ignores_valid", n_valid, 0);
    check_eq("time_after_errs",    32'(spike_time), 5);

    // Rise on the grst cycle -> t=0.
    cyc(1'b1, 1'b1);
    run(1'b0, 1'b1, 7);
    cyc(1'b0, 1'b0);
    check_eq("valid_t0", 32'(spike_valid), 1);
    check_eq("time_t0",  32'(spike_time), 0);

    // Late rise (k=21 -> t would be 20) saturates at 15.
    cyc(1'b1, 1'b0);
    run(1'b0, 1'b0, 20);
    run(1'b0, 1'b1, 8);
    cyc(1'b0, 1'b0);
    check_eq("valid_sat", 32'(spike_valid), 1);
    check_eq("time_sat",  32'(spike_time), 15);

    // grst at width 4 truncates; the still-high input is not a new rise.
    cyc(1'b1, 1'b0);
    run(1'b0, 1'b1, 4);
    cyc(1'b1, 1'b1);
    check_eq("err_truncate",   32'(pulse_err), 1);
    check_eq("valid_truncate", 32'(spike_valid), 0);
    check_eq("nospk_truncate", 32'(no_spike), 0);
    clr_counts();
    run(1'b0, 1'b1, 8);
    cyc(1'b0, 1'b0);
    check_eq("no_rerise_err",   n_err, 0);
    check_eq("no_rerise_valid", n_valid, 0);
    // Truncation grst edge cleared t; rise at k=10 -> t=9.
    run(1'b0, 1'b1, 8);
    cyc(1'b0, 1'b0);
    check_eq("valid_after_trunc", 32'(spike_valid), 1);
    check_eq("time_after_trunc",  32'(spike_time), 9);
    clr_counts();
    cyc(1'b0, 1'b1);
    check_eq("err_second_pulse", 32'(pulse_err), 1);
    run(1'b0, 1'b1, 7);
    cyc(1'b0, 1'b0);
    check_eq("second_pulse_errs",  n_err, 1);
    check_eq("second_pulse_valid", n_valid, 0);
    check_eq("second_pulse_time",  32'(spike_time), 9);

    // Async reset mid-pulse, then a rise with no grst since reset: t=2.
    cyc(1'b1, 1'b0);
    run(1'b0, 1'b1, 3);
    #2;
    rstb     = 1'b0;
    spike_in = 1'b0;
    #1;
    check_eq("async_rst_time",  32'(spike_time), 0);
    check_eq("async_rst_valid", 32'(spike_valid), 0);
    check_eq("async_rst_err",   32'(pulse_err), 0);
    check_eq("async_rst_nospk", 32'(no_spike), 0);
    @(posedge clk);
    #1;
    rstb = 1'b1;
    run(1'b0, 1'b0, 2);
    run(1'b0, 1'b1, 8);
    cyc(1'b0, 1'b0);
    check_eq("valid_post_rst", 32'(spike_valid), 1);
    check_eq("time_post_rst",  32'(spike_time), 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
